// File: rtl/uart_pkg.sv
// Register map, bit positions and CTRL layout shared by the UART RX controller.
package uart_pkg;

    localparam int unsigned BUS_W      = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned REG_ADDR_W = 2;

    localparam logic [REG_ADDR_W-1:0] REG_DATA   = 2'd0;
    localparam logic [REG_ADDR_W-1:0] REG_STATUS = 2'd1;
    localparam logic [REG_ADDR_W-1:0] REG_CTRL   = 2'd2;
    localparam logic [REG_ADDR_W-1:0] REG_CLEAR  = 2'd3;

    localparam int unsigned DATA_EMPTY_BIT = 31;

    localparam int unsigned STAT_EMPTY_BIT = 16;
    localparam int unsigned STAT_FULL_BIT  = 17;
    localparam int unsigned STAT_OVR_BIT   = 18;
    localparam int unsigned STAT_TMO_BIT   = 19;

    localparam int unsigned CTRL_RX_EN_BIT  = 0;
    localparam int unsigned CTRL_IE_LVL_BIT = 1;
    localparam int unsigned CTRL_IE_OVR_BIT = 2;
    localparam int unsigned CTRL_IE_TMO_BIT = 3;
    localparam int unsigned CTRL_THRESH_LSB = 8;

    localparam int unsigned CLR_FLUSH_BIT = 0;
    localparam int unsigned CLR_OVR_BIT   = 1;
    localparam int unsigned CLR_TMO_BIT   = 2;

    typedef struct packed {
        logic [BYTE_W-1:0] thresh;
        logic              ie_tmo;
        logic              ie_ovr;
        logic              ie_lvl;
        logic              rx_en;
    } ctrl_reg_t;

    // Expand the stored CTRL fields into their bus-visible positions.
    function automatic logic [BUS_W-1:0] ctrl_to_word(input ctrl_reg_t c);
        logic [BUS_W-1:0] w;
        w                                = '0;
        w[CTRL_RX_EN_BIT]                = c.rx_en;
        w[CTRL_IE_LVL_BIT]               = c.ie_lvl;
        w[CTRL_IE_OVR_BIT]               = c.ie_ovr;
        w[CTRL_IE_TMO_BIT]               = c.ie_tmo;
        w[CTRL_THRESH_LSB +: BYTE_W]     = c.thresh;
        return w;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO: push/pop/flush, head on dout_c, registered level.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] dout_c,
    output logic [LVL_W-1:0] level,
    output logic             full_c,
    output logic             empty_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign empty_c = (level_q == '0);
    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign level   = level_q;
    assign dout_c  = mem_q[rd_ptr_q];

    // A push into a full FIFO only lands when a pop frees the head slot this cycle.
    assign do_pop  = pop & ~empty_c;
    assign do_push = push & (~full_c | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; contents are only observable through level.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: byte stream into a FIFO, 4-register CPU window, overrun and irq.
// Optional receive timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4340
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        irq
);

    import uart_pkg::*;

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    ctrl_reg_t         ctrl_q, ctrl_d;
    logic              ready_q, ready_d;
    logic              ovr_q, ovr_d;
    logic              tmo_q, tmo_d;
    logic [BUS_W-1:0]  rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              irq_q, irq_d;

    logic              rd_c;
    logic              wr_c;
    logic              clr_wr_c;
    logic              push_c;
    logic              pop_c;
    logic              flush_c;
    logic              ovr_set_c;
    logic [BYTE_W-1:0] fifo_dout;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic              unused_wdata;

    assign rd_c      = req & ~we;
    assign wr_c      = req & we;
    assign clr_wr_c  = wr_c & (addr == REG_CLEAR);
    assign push_c    = rx_data_valid & ready_q & ctrl_q.rx_en;
    assign pop_c     = rd_c & (addr == REG_DATA);
    assign flush_c   = clr_wr_c & wdata[CLR_FLUSH_BIT];
    // Overrun only when the byte is truly lost: no room, no pop, not swallowed by a flush.
    assign ovr_set_c = push_c & fifo_full & ~(pop_c & ~fifo_empty) & ~flush_c;

    assign unused_wdata = ^{wdata[31:16], wdata[7:4]};

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .din     (rx_data),
        .pop     (pop_c),
        .flush   (flush_c),
        .dout_c  (fifo_dout),
        .level   (fifo_level),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TMO_CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 tmo_set_c;

    // Count idle cycles while data waits; flag once on reaching the limit, then hold.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_set_c = 1'b0;
        if (push_c || pop_c || flush_c || fifo_empty) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
            tmo_set_c = (tmo_cnt_d == TMO_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end

    assign tmo_d = tmo_set_c | (tmo_q & ~(clr_wr_c & wdata[CLR_TMO_BIT]));
`else
    logic unused_tmo;

    assign tmo_d      = 1'b0;
    assign unused_tmo = wdata[CLR_TMO_BIT] ^ (TIMEOUT_CYCLES == 0);
`endif

    // Register file, sticky overrun, read mux and interrupt.
    always_comb begin
        ready_d  = 1'b1;
        ctrl_d   = ctrl_q;
        ovr_d    = ovr_set_c | (ovr_q & ~(clr_wr_c & wdata[CLR_OVR_BIT]));
        rdata_d  = rdata_q;
        rvalid_d = rd_c;
        irq_d    = 1'b0;

        if (wr_c && (addr == REG_CTRL)) begin
            ctrl_d.rx_en  = wdata[CTRL_RX_EN_BIT];
            ctrl_d.ie_lvl = wdata[CTRL_IE_LVL_BIT];
            ctrl_d.ie_ovr = wdata[CTRL_IE_OVR_BIT];
            ctrl_d.ie_tmo = wdata[CTRL_IE_TMO_BIT];
            ctrl_d.thresh = wdata[CTRL_THRESH_LSB +: BYTE_W];
        end

        if (rd_c) begin
            rdata_d = '0;
            case (addr)
                REG_DATA: begin
                    rdata_d[DATA_EMPTY_BIT] = fifo_empty;
                    if (!fifo_empty) rdata_d[BYTE_W-1:0] = fifo_dout;
                end
                REG_STATUS: begin
                    rdata_d[LVL_W-1:0]     = fifo_level;
                    rdata_d[STAT_EMPTY_BIT] = fifo_empty;
                    rdata_d[STAT_FULL_BIT]  = fifo_full;
                    rdata_d[STAT_OVR_BIT]   = ovr_q;
                    rdata_d[STAT_TMO_BIT]   = tmo_q;
                end
                REG_CTRL: rdata_d = ctrl_to_word(ctrl_q);
                default:  rdata_d = '0;
            endcase
        end

        irq_d = (ctrl_q.ie_lvl && (ctrl_q.thresh != '0)
                 && (BUS_W'(fifo_level) >= BUS_W'(ctrl_q.thresh)))
              | (ctrl_q.ie_ovr & ovr_q)
              | (ctrl_q.ie_tmo & tmo_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            ready_q  <= 1'b0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            ready_q  <= ready_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign rx_data_ready = ready_q;
    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: reads queue expectations, a monitor checks rvalid data.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 8;
    localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_CLR = 2'd3;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
    localparam logic [31:0] SM  = 32'hFFF7_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mask_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .req           (req),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .irq           (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pops one expectation.
    initial begin
        logic [31:0] e;
        logic [31:0] m;
        string       n;
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rdata %h expected no response", rdata);
                end else begin
                    e = exp_q.pop_front();
                    m = mask_q.pop_front();
                    n = name_q.pop_front();
                    check(n, rdata & m, e & m);
                end
            end
        end
    end

    task automatic step(input logic vld, input logic [7:0] b, input logic rq, input logic w,
                        input logic [1:0] a, input logic [31:0] wd);
        rx_data_valid = vld;
        rx_data       = b;
        req           = rq;
        we            = w;
        addr          = a;
        wdata         = wd;
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
        req           = 1'b0;
        we            = 1'b0;
    endtask

    task automatic expect_rd(input logic [31:0] e, input logic [31:0] m, input string n);
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(n);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b0, 8'h00, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic [31:0] m, input string n);
        expect_rd(e, m, n);
        step(1'b0, 8'h00, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic push(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0, A_DATA, 32'h0);
    endtask

    initial begin
        int waited;
        rst = 1'b1; rx_data = '0; rx_data_valid = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  32'(rx_data_ready), 32'h0);
        check("rst_rdata",  rdata, 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_irq",    32'(irq), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", 32'(rx_data_ready), 32'h1);

        // Single byte through the FIFO, plus register readbacks.
        wr(A_CTRL, 32'h1);
        push(8'hA5);
        rd(A_STAT, 32'h0000_0001, SM, "t1_status");
        rd(A_DATA, 32'h0000_00A5, ALL, "t1_data");
        rd(A_DATA, 32'h8000_0000, ALL, "t1_empty_read");
        rd(A_CTRL, 32'h0000_0001, ALL, "ctrl_readback");
        rd(A_CLR,  32'h0000_0000, ALL, "clear_reads_zero");

        // Overfill by one: full and overrun.
        for (int i = 0; i <= 16; i++) push(8'(i));
        rd(A_STAT, 32'h0006_0010, SM, "t2_full_ovr");
        wr(A_CLR, 32'h2);
        rd(A_STAT, 32'h0002_0010, SM, "t2_ovr_cleared");

        // Push and pop together at full.
        expect_rd(32'h0000_0000, ALL, "t3_pop_head");
        step(1'b1, 8'h77, 1'b1, 1'b0, A_DATA, 32'h0);
        rd(A_STAT, 32'h0002_0010, SM, "t3_level_kept");
        for (int i = 1; i <= 15; i++) rd(A_DATA, 32'(i), ALL, "t2_order");
        rd(A_DATA, 32'h0000_0077, ALL, "t3_pushed_tail");
        rd(A_DATA, 32'h8000_0000, ALL, "t2_drained");

        // Level threshold interrupt.
        wr(A_CTRL, 32'h0000_0403);
        rd(A_CTRL, 32'h0000_0403, ALL, "t4_ctrl_readback");
        push(8'h10); push(8'h11); push(8'h12);
        @(negedge clk);
        check("t4_irq_below", 32'(irq), 32'h0);
        push(8'h13);
        @(negedge clk);
        check("t4_irq_latency", 32'(irq), 32'h0);
        @(negedge clk);
        check("t4_irq_set", 32'(irq), 32'h1);
        rd(A_DATA, 32'h0000_0010, ALL, "t4_pop");
        @(negedge clk);
        check("t4_irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check("t4_irq_clear", 32'(irq), 32'h0);
        wr(A_CLR, 32'h1);
        rd(A_STAT, 32'h0001_0000, SM, "t4_flushed");

        // Overrun interrupt, then flush racing a push at full.
        wr(A_CTRL, 32'h5);
        for (int i = 0; i <= 16; i++) push(8'(8'h40 + i));
        @(negedge clk);
        @(negedge clk);
        check("ovr_irq_set", 32'(irq), 32'h1);
        wr(A_CLR, 32'h2);
        @(negedge clk);
        @(negedge clk);
        check("ovr_irq_clear", 32'(irq), 32'h0);
        step(1'b1, 8'hEE, 1'b1, 1'b1, A_CLR, 32'h1);
        rd(A_STAT, 32'h0001_0000, SM, "flush_beats_push");

        // Receiver disabled: byte accepted but discarded.
        wr(A_CTRL, 32'h0);
        push(8'h3C);
        @(negedge clk);
        check("t5_ready", 32'(rx_data_ready), 32'h1);
        rd(A_STAT, 32'h0001_0000, SM, "t5_level0");
        rd(A_DATA, 32'h8000_0000, ALL, "t5_empty_read");

        // Idle timeout.
        wr(A_CTRL, 32'h1);
        wr(A_CLR, 32'h4);
        push(8'h55);
        repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0, A_DATA, 32'h0);
`ifdef UART_RX_TIMEOUT_EN
        rd(A_STAT, 32'h0008_0001, ALL, "t6_tmo_set");
        wr(A_CLR, 32'h4);
        rd(A_STAT, 32'h0000_0001, ALL, "t6_tmo_clear");
`else
        rd(A_STAT, 32'h0000_0001, ALL, "t6_tmo_absent");
`endif
        rd(A_DATA, 32'h0000_0055, ALL, "t6_data");

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
